// File: rtl/pulse_sync_toggle_rx_mc_if.sv
// Event port of the toggle-pulse receiver: valid/ready handshake tagged with a channel index.
interface pulse_sync_toggle_rx_mc_if #(
    parameter int CH_W = 2
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/pulse_sync_toggle_rx_mc.sv
// Destination-side receiver for N toggle-encoded pulse channels, serialised onto one event port.
// Define PSTR_ROUND_ROBIN_EN for round-robin channel selection; otherwise lowest index wins.
module pulse_sync_toggle_rx_mc #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    parameter int CH_W        = 2
) (
    input  logic                            clock_b,
    input  logic                            async_rst_n,
    input  logic [NUM_CH-1:0]               tgl_a,
    output logic [NUM_CH-1:0]               pls_b,
    pulse_sync_toggle_rx_mc_if.master       evt,
    output logic [NUM_CH-1:0]               ovf,
    input  logic [NUM_CH-1:0]               ovf_clr,
    output logic                            busy
);

    logic [NUM_CH-1:0] pend_nz;
    logic [NUM_CH-1:0] dec;
    logic              evt_valid_reg;
    logic [CH_W-1:0]   evt_ch_reg;
    logic [CH_W-1:0]   sel;
    logic              sel_found;
    logic              load;

    // The output register refills whenever it is empty or being accepted this cycle.
    assign load = !evt_valid_reg || evt.evt_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   d_reg;
            logic [CNT_W-1:0]       pend_reg;
            logic                   ovf_reg;
            logic                   inc;
            logic                   ovf_set;

            always_ff @(posedge clock_b or negedge async_rst_n) begin
                if (!async_rst_n) begin
                    sync_reg <= '0;
                    d_reg    <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], tgl_a[gi]};
                    d_reg    <= sync_reg[SYNC_STAGES-1];
                end
            end

            assign pls_b[gi] = sync_reg[SYNC_STAGES-1] ^ d_reg;
            assign inc       = pls_b[gi];
            assign dec[gi]   = load && sel_found && (sel == CH_W'(gi));
            // A pulse arriving on a full counter with no drain this cycle is lost.
            assign ovf_set   = inc && !dec[gi] && (pend_reg == '1);

            always_ff @(posedge clock_b or negedge async_rst_n) begin
                if (!async_rst_n) begin
                    pend_reg <= '0;
                    ovf_reg  <= 1'b0;
                end else begin
                    if (inc && !dec[gi] && !ovf_set) begin
                        pend_reg <= pend_reg + 1'b1;
                    end else if (dec[gi] && !inc) begin
                        pend_reg <= pend_reg - 1'b1;
                    end
                    if (ovf_set) begin
                        ovf_reg <= 1'b1;
                    end else if (ovf_clr[gi]) begin
                        ovf_reg <= 1'b0;
                    end
                end
            end

            assign pend_nz[gi] = |pend_reg;
            assign ovf[gi]     = ovf_reg;
        end
    endgenerate

`ifdef PSTR_ROUND_ROBIN_EN
    logic [CH_W-1:0] ptr_reg;

    // Search begins just after the most recently loaded channel and wraps.
    always_comb begin
        int idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = int'(ptr_reg) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!sel_found && pend_nz[idx]) begin
                sel_found = 1'b1;
                sel       = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clock_b or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ptr_reg <= CH_W'(NUM_CH - 1);
        end else if (load && sel_found) begin
            ptr_reg <= sel;
        end
    end
`else
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_nz[i]) begin
                sel_found = 1'b1;
                sel       = CH_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clock_b or negedge async_rst_n) begin
        if (!async_rst_n) begin
            evt_valid_reg <= 1'b0;
            evt_ch_reg    <= '0;
        end else if (load) begin
            if (sel_found) begin
                evt_valid_reg <= 1'b1;
                evt_ch_reg    <= sel;
            end else begin
                evt_valid_reg <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = evt_valid_reg;
    assign evt.evt_ch    = evt_ch_reg;
    assign busy          = evt_valid_reg | (|pend_nz);

endmodule

// File: tb/tb_pulse_sync_toggle_rx_mc.sv
// Directed + randomized bench for pulse_sync_toggle_rx_mc with an event-count reference model.
module tb_pulse_sync_toggle_rx_mc;
    localparam int NUM_CH = 4;
    localparam int SS     = 2;
    localparam int CNT_W  = 3;
    localparam int CH_W   = 2;
    localparam int MAXP   = (1 << CNT_W) - 1;

    logic              clk;
    logic              async_rst_n;
    logic [NUM_CH-1:0] tgl_a;
    logic [NUM_CH-1:0] pls_b;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] ovf_clr;
    logic              busy;

    pulse_sync_toggle_rx_mc_if #(.CH_W(CH_W)) evt_if ();

    pulse_sync_toggle_rx_mc #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SS), .CNT_W(CNT_W), .CH_W(CH_W)
    ) dut (
        .clock_b    (clk),
        .async_rst_n(async_rst_n),
        .tgl_a      (tgl_a),
        .pls_b      (pls_b),
        .evt        (evt_if),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int drops  = 0;
    int rx_q[$];

    // Reference model: event counts per channel and the presented event.
    logic [NUM_CH-1:0] hist_m [0:SS];
    int                pend_m [NUM_CH];
    logic [NUM_CH-1:0] ovf_m;
    bit                vld_m;
    int                ch_m;
    int                ptr_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j <= SS; j++) hist_m[j] = '0;
        for (int i = 0; i < NUM_CH; i++) pend_m[i] = 0;
        ovf_m = '0;
        vld_m = 1'b0;
        ch_m  = 0;
        ptr_m = NUM_CH - 1;
    endtask

    function automatic logic [NUM_CH-1:0] pls_m();
        return hist_m[SS-1] ^ hist_m[SS];
    endfunction

    task automatic model_edge();
        logic [NUM_CH-1:0] p;
        int sel;
        p   = pls_m();
        sel = -1;
        if (!vld_m || evt_if.evt_ready) begin
`ifdef PSTR_ROUND_ROBIN_EN
            for (int off = 1; off <= NUM_CH; off++)
                if (sel < 0 && pend_m[(ptr_m + off) % NUM_CH] > 0) sel = (ptr_m + off) % NUM_CH;
`else
            for (int i = 0; i < NUM_CH; i++)
                if (sel < 0 && pend_m[i] > 0) sel = i;
`endif
            if (sel >= 0) begin
                vld_m = 1'b1;
                ch_m  = sel;
                ptr_m = sel;
                pend_m[sel]--;
            end else begin
                vld_m = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            bit set_i;
            set_i = 1'b0;
            if (p[i]) begin
                if (i == sel) pend_m[i]++;
                else if (pend_m[i] == MAXP) begin
                    set_i = 1'b1;
                    drops++;
                end else pend_m[i]++;
            end
            if (set_i) ovf_m[i] = 1'b1;
            else if (ovf_clr[i]) ovf_m[i] = 1'b0;
        end
        for (int j = SS; j >= 1; j--) hist_m[j] = hist_m[j-1];
        hist_m[0] = tgl_a;
    endtask

    task automatic compare_all();
        bit any_p;
        any_p = 1'b0;
        for (int i = 0; i < NUM_CH; i++) if (pend_m[i] > 0) any_p = 1'b1;
        check("pls_b", pls_b, pls_m());
        check("evt_valid", evt_if.evt_valid, vld_m);
        if (vld_m) check("evt_ch", evt_if.evt_ch, ch_m);
        check("ovf", ovf, ovf_m);
        check("busy", busy, vld_m | any_p);
    endtask

    task automatic step();
        if (async_rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            rx_q.push_back(int'(evt_if.evt_ch));
            $display("evt accepted ch=%0d cyc=%0d", evt_if.evt_ch, cyc);
        end
        @(posedge clk);
        cyc++;
        if (!async_rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic toggle(input int ch);
        tgl_a[ch] = ~tgl_a[ch];
    endtask

    initial begin
        int exp5[5];
        int last_t[NUM_CH];
        int n_tgl;
        int rx0;
        int drop0;

        tgl_a              = '0;
        ovf_clr            = '0;
        evt_if.evt_ready   = 1'b0;
        async_rst_n        = 1'b1;
        model_reset();
        #1 async_rst_n     = 1'b0;

        // 1: reset then idle
        wait_n(3);
        async_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("idle_valid", evt_if.evt_valid, 1'b0);
            check("idle_busy", busy, 1'b0);
        end

        // 2: single toggle on ch2 with ready high
        evt_if.evt_ready = 1'b1;
        rx_q.delete();
        toggle(2);
        step(); check("t2_pls_e1", pls_b[2], 1'b0);
        step(); check("t2_pls_e2", pls_b[2], 1'b1);
        step(); check("t2_pls_e3", pls_b[2], 1'b0);
                check("t2_busy_e3", busy, 1'b1);
                check("t2_valid_e3", evt_if.evt_valid, 1'b0);
        step(); check("t2_valid_e4", evt_if.evt_valid, 1'b1);
                check("t2_ch_e4", evt_if.evt_ch, 2'd2);
        step(); check("t2_valid_e5", evt_if.evt_valid, 1'b0);
                check("t2_busy_e5", busy, 1'b0);
        wait_n(3);
        check("t2_count", rx_q.size(), 1);

        // 3: overflow on ch1 with the consumer stalled
        evt_if.evt_ready = 1'b0;
        rx_q.delete();
        for (int k = 0; k < 9; k++) begin
            toggle(1);
            wait_n(4);
        end
        wait_n(4);
        check("t3_ovf1", ovf[1], 1'b1);
        check("t3_valid", evt_if.evt_valid, 1'b1);
        evt_if.evt_ready = 1'b1;
        wait_n(12);
        check("t3_count", rx_q.size(), 8);
        for (int k = 0; k < rx_q.size(); k++) check("t3_ch", rx_q[k], 1);
        ovf_clr[1] = 1'b1;
        step();
        ovf_clr[1] = 1'b0;
        check("t3_ovf_clr", ovf[1], 1'b0);

        // 4: presented event held stable during a stall
        evt_if.evt_ready = 1'b0;
        toggle(2);
        wait_n(5);
        check("t4_valid", evt_if.evt_valid, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 1 || k == 6) toggle(0);
            step();
            check("t4_hold_ch", evt_if.evt_ch, 2'd2);
        end
        evt_if.evt_ready = 1'b1;
        wait_n(10);

        // 5: arbitration order with two busy channels
        evt_if.evt_ready = 1'b0;
        rx_q.delete();
        toggle(0);
        step();
        toggle(3);
        wait_n(5);
        toggle(0); toggle(3);
        wait_n(5);
        toggle(0);
        wait_n(6);
        evt_if.evt_ready = 1'b1;
        wait_n(10);
`ifdef PSTR_ROUND_ROBIN_EN
        exp5 = '{0, 3, 0, 3, 0};
`else
        exp5 = '{0, 0, 0, 3, 3};
`endif
        check("t5_count", rx_q.size(), 5);
        for (int k = 0; k < 5 && k < rx_q.size(); k++) check("t5_order", rx_q[k], exp5[k]);

        // 6: asynchronous reset while work is pending
        evt_if.evt_ready = 1'b0;
        toggle(1); toggle(2);
        wait_n(5);
        toggle(1);
        wait_n(5);
        check("t6_pre_busy", busy, 1'b1);
        check("t6_pre_valid", evt_if.evt_valid, 1'b1);
        #2 async_rst_n = 1'b0;
        tgl_a = '0;
        #1;
        model_reset();
        check("t6_rst_valid", evt_if.evt_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_pls", pls_b, '0);
        check("t6_rst_ovf", ovf, '0);
        wait_n(3);
        async_rst_n = 1'b1;
        rx_q.delete();
        evt_if.evt_ready = 1'b1;
        wait_n(20);
        check("t6_no_events", rx_q.size(), 0);

        // Random phase: every non-dropped toggle must surface as exactly one event
        for (int i = 0; i < NUM_CH; i++) last_t[i] = -100;
        n_tgl = 0;
        rx0   = rx_q.size();
        drop0 = drops;
        for (int k = 0; k < 800; k++) begin
            evt_if.evt_ready = ($urandom_range(0, 9) < 4);
            for (int i = 0; i < NUM_CH; i++) begin
                ovf_clr[i] = ($urandom_range(0, 19) == 0);
                if (k - last_t[i] >= SS + 2 && $urandom_range(0, 5) == 0) begin
                    toggle(i);
                    last_t[i] = k;
                    n_tgl++;
                end
            end
            step();
        end
        ovf_clr = '0;
        evt_if.evt_ready = 1'b1;
        wait_n(40);
        check("rand_events", rx_q.size() - rx0, n_tgl - (drops - drop0));
        check("rand_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
